// File: rtl/jk_bank_sequencer_if.sv
// Command handshake bundle between a controller and jk_bank_sequencer.
// The master offers a command; the slave raises cmd_ready while it can take one.
interface jk_bank_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_len;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    output cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    input  cmd_len,
    output cmd_ready
  );
endinterface

// File: rtl/jk_bank_sequencer.sv
// Sequences J/K drive vectors for an external JK flip-flop bank and checks its Q feedback.
// Define JKSEQ_DOWN_COUNT_EN to add CNT_DN (op 6); otherwise op 6 is treated as illegal.
module jk_bank_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  jk_bank_sequencer_if.slave   cmd,
  input  logic [WIDTH-1:0]     q_in,
  output logic [WIDTH-1:0]     j_out,
  output logic [WIDTH-1:0]     k_out,
  output logic                 busy,
  output logic                 done,
  output logic                 mismatch,
  output logic                 illegal,
  output logic                 wrap
);

  typedef enum logic [1:0] {IDLE, APPLY, COUNT, CHECK} state_t;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_CLEAR  = 3'd2;
  localparam logic [2:0] OP_SET    = 3'd3;
  localparam logic [2:0] OP_TOGGLE = 3'd4;
  localparam logic [2:0] OP_CNT_UP = 3'd5;
`ifdef JKSEQ_DOWN_COUNT_EN
  localparam logic [2:0] OP_CNT_DN = 3'd6;
`endif

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  state_t           stateReg;
  logic [WIDTH-1:0] expReg;
  logic [CNT_W-1:0] remReg;
  logic [WIDTH-1:0] upMask;

  // A bit toggles on a one-step count iff every lower bit is 1 (up) / 0 (down).
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_up_mask
      if (gi == 0) begin : g_lsb
        assign upMask[gi] = 1'b1;
      end else begin : g_upper
        assign upMask[gi] = &expReg[gi-1:0];
      end
    end
  endgenerate

`ifdef JKSEQ_DOWN_COUNT_EN
  logic [WIDTH-1:0] downMask;
  logic             countDownReg;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_down_mask
      if (gi == 0) begin : g_lsb
        assign downMask[gi] = 1'b1;
      end else begin : g_upper
        assign downMask[gi] = ~|expReg[gi-1:0];
      end
    end
  endgenerate
`endif

  assign cmd.cmd_ready = (stateReg == IDLE);
  assign busy          = (stateReg != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= IDLE;
      expReg   <= '0;
      remReg   <= '0;
      j_out    <= '0;
      k_out    <= '0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      wrap     <= 1'b0;
      mismatch <= 1'b0;
`ifdef JKSEQ_DOWN_COUNT_EN
      countDownReg <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      wrap    <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (cmd.cmd_valid) begin
            case (cmd.cmd_op)
              OP_NOP: done <= 1'b1;
              OP_LOAD: begin
                j_out    <= cmd.cmd_data;
                k_out    <= ~cmd.cmd_data;
                expReg   <= cmd.cmd_data;
                stateReg <= APPLY;
              end
              OP_CLEAR: begin
                j_out    <= '0;
                k_out    <= ALL_ONES;
                expReg   <= '0;
                stateReg <= APPLY;
              end
              OP_SET: begin
                j_out    <= ALL_ONES;
                k_out    <= '0;
                expReg   <= ALL_ONES;
                stateReg <= APPLY;
              end
              OP_TOGGLE: begin
                j_out    <= cmd.cmd_data;
                k_out    <= cmd.cmd_data;
                expReg   <= expReg ^ cmd.cmd_data;
                stateReg <= APPLY;
              end
              OP_CNT_UP: begin
                remReg   <= cmd.cmd_len;
                stateReg <= COUNT;
`ifdef JKSEQ_DOWN_COUNT_EN
                countDownReg <= 1'b0;
`endif
              end
`ifdef JKSEQ_DOWN_COUNT_EN
              OP_CNT_DN: begin
                remReg       <= cmd.cmd_len;
                countDownReg <= 1'b1;
                stateReg     <= COUNT;
              end
`endif
              default: begin
                illegal <= 1'b1;
                done    <= 1'b1;
              end
            endcase
          end
        end
        APPLY: begin
          j_out    <= '0;
          k_out    <= '0;
          stateReg <= CHECK;
        end
        COUNT: begin
          if (remReg != '0) begin
            remReg <= remReg - 1'b1;
`ifdef JKSEQ_DOWN_COUNT_EN
            if (countDownReg) begin
              j_out  <= downMask;
              k_out  <= downMask;
              expReg <= expReg - 1'b1;
              wrap   <= ~|expReg;
            end else begin
              j_out  <= upMask;
              k_out  <= upMask;
              expReg <= expReg + 1'b1;
              wrap   <= &expReg;
            end
`else
            j_out  <= upMask;
            k_out  <= upMask;
            expReg <= expReg + 1'b1;
            wrap   <= &expReg;
`endif
          end else begin
            j_out    <= '0;
            k_out    <= '0;
            stateReg <= CHECK;
          end
        end
        CHECK: begin
          if (q_in != expReg) mismatch <= 1'b1;
          done     <= 1'b1;
          stateReg <= IDLE;
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench for jk_bank_sequencer driving a behavioural 4-bit JK bank.
// Inputs change and outputs are sampled on the falling edge.
module tb_jk_bank_sequencer;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] q_in;
  logic [WIDTH-1:0] j_out;
  logic [WIDTH-1:0] k_out;
  logic             busy;
  logic             done;
  logic             mismatch;
  logic             illegal;
  logic             wrap;
  logic             bankStuck = 1'b0;
  int               nChecks = 0;
  int               nPass = 0;

  jk_bank_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cmdIf ();

  jk_bank_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd      (cmdIf),
    .q_in     (q_in),
    .j_out    (j_out),
    .k_out    (k_out),
    .busy     (busy),
    .done     (done),
    .mismatch (mismatch),
    .illegal  (illegal),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  // JK bank: 00 hold, 01 reset, 10 set, 11 toggle; bankStuck disconnects it.
  always_ff @(posedge clk) begin
    if (reset) q_in <= '0;
    else if (!bankStuck) q_in <= (j_out & ~q_in) | (~k_out & q_in);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Called at a falling edge; returns at the falling edge just after the accept edge.
  task automatic sendCmd(input logic [2:0] op, input logic [WIDTH-1:0] data,
                         input logic [CNT_W-1:0] len);
    cmdIf.cmd_valid = 1'b1;
    cmdIf.cmd_op    = op;
    cmdIf.cmd_data  = data;
    cmdIf.cmd_len   = len;
    $display("txn op=%0d data=%b len=%0d q=%b", op, data, len, q_in);
    @(posedge clk);
    @(negedge clk);
    cmdIf.cmd_valid = 1'b0;
  endtask

  task automatic doLoad(input logic [WIDTH-1:0] data);
    sendCmd(3'd1, data, '0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    cmdIf.cmd_valid = 1'b0;
    cmdIf.cmd_op    = '0;
    cmdIf.cmd_data  = '0;
    cmdIf.cmd_len   = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    nChecks++;
    if ({j_out, k_out} !== 8'h00)
      $display("FAIL reset_jk: got j=%b k=%b, required 0000/0000", j_out, k_out);
    else nPass++;
    nChecks++;
    if ({cmdIf.cmd_ready, busy, done, mismatch, illegal, wrap} !== 6'b100000)
      $display("FAIL reset_flags: got rdy/busy/done/mis/ill/wrap=%b, required 100000",
               {cmdIf.cmd_ready, busy, done, mismatch, illegal, wrap});
    else nPass++;
  endtask

  task automatic test_load();
    sendCmd(3'd1, 4'b1010, '0);
    nChecks++;
    if ({j_out, k_out, busy} !== {4'b1010, 4'b0101, 1'b1})
      $display("FAIL load_drive: got j=%b k=%b busy=%b, required 1010/0101/1", j_out, k_out, busy);
    else nPass++;
    @(negedge clk);
    nChecks++;
    if ({j_out, k_out, done} !== 9'b0)
      $display("FAIL load_apply: got j=%b k=%b done=%b, required 0000/0000/0", j_out, k_out, done);
    else nPass++;
    @(negedge clk);
    nChecks++;
    if ({done, cmdIf.cmd_ready, mismatch, q_in} !== {3'b110, 4'b1010})
      $display("FAIL load_done: got done/rdy/mis=%b q=%b, required 110/1010",
               {done, cmdIf.cmd_ready, mismatch}, q_in);
    else nPass++;
  endtask

  task automatic test_toggle();
    sendCmd(3'd4, 4'b0110, '0);
    nChecks++;
    if ({j_out, k_out} !== {4'b0110, 4'b0110})
      $display("FAIL toggle_drive: got j=%b k=%b, required 0110/0110", j_out, k_out);
    else nPass++;
    @(negedge clk);
    nChecks++;
    if (done !== 1'b0) $display("FAIL toggle_early_done: got %b, required 0", done);
    else nPass++;
    @(negedge clk);
    nChecks++;
    if ({done, mismatch, q_in} !== {2'b10, 4'b1100})
      $display("FAIL toggle_done: got done/mis=%b q=%b, required 10/1100", {done, mismatch}, q_in);
    else nPass++;
  endtask

  task automatic test_cnt_up();
    logic [WIDTH-1:0] jExp [4] = '{4'b0001, 4'b1111, 4'b0001, 4'b0000};
    logic             wExp [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [WIDTH-1:0] qExp [4] = '{4'b1110, 4'b1111, 4'b0000, 4'b0001};
    doLoad(4'b1110);
    sendCmd(3'd5, '0, 8'd3);
    nChecks++;
    if ({j_out, busy} !== {4'b0000, 1'b1})
      $display("FAIL cnt_up_accept: got j=%b busy=%b, required 0000/1", j_out, busy);
    else nPass++;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      nChecks++;
      if ({j_out, k_out, wrap, q_in} !== {jExp[s], jExp[s], wExp[s], qExp[s]})
        $display("FAIL cnt_up_step%0d: got j=%b k=%b wrap=%b q=%b, required j=k=%b wrap=%b q=%b",
                 s, j_out, k_out, wrap, q_in, jExp[s], wExp[s], qExp[s]);
      else nPass++;
    end
    @(negedge clk);
    nChecks++;
    if ({done, mismatch, q_in} !== {2'b10, 4'b0001})
      $display("FAIL cnt_up_done: got done/mis=%b q=%b, required 10/0001", {done, mismatch}, q_in);
    else nPass++;
  endtask

  task automatic test_cnt_dn();
`ifdef JKSEQ_DOWN_COUNT_EN
    logic [WIDTH-1:0] jExp [3] = '{4'b0001, 4'b1111, 4'b0000};
    logic             wExp [3] = '{1'b0, 1'b1, 1'b0};
    logic [WIDTH-1:0] qExp [3] = '{4'b0001, 4'b0000, 4'b1111};
    sendCmd(3'd6, '0, 8'd2);
    nChecks++;
    if ({illegal, busy} !== 2'b01)
      $display("FAIL cnt_dn_accept: got illegal/busy=%b, required 01", {illegal, busy});
    else nPass++;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      nChecks++;
      if ({j_out, k_out, wrap, q_in} !== {jExp[s], jExp[s], wExp[s], qExp[s]})
        $display("FAIL cnt_dn_step%0d: got j=%b k=%b wrap=%b q=%b, required j=k=%b wrap=%b q=%b",
                 s, j_out, k_out, wrap, q_in, jExp[s], wExp[s], qExp[s]);
      else nPass++;
    end
    @(negedge clk);
    nChecks++;
    if ({done, mismatch, q_in} !== {2'b10, 4'b1111})
      $display("FAIL cnt_dn_done: got done/mis=%b q=%b, required 10/1111", {done, mismatch}, q_in);
    else nPass++;
`else
    sendCmd(3'd6, '0, 8'd2);
    nChecks++;
    if ({illegal, done, cmdIf.cmd_ready, j_out, k_out} !== {3'b111, 8'h00})
      $display("FAIL cnt_dn_illegal: got ill/done/rdy=%b j=%b k=%b, required 111/0000/0000",
               {illegal, done, cmdIf.cmd_ready}, j_out, k_out);
    else nPass++;
    @(negedge clk);
    nChecks++;
    if ({illegal, done, q_in} !== {2'b00, 4'b0001})
      $display("FAIL cnt_dn_after: got ill/done=%b q=%b, required 00/0001", {illegal, done}, q_in);
    else nPass++;
`endif
  endtask

  task automatic test_illegal_nop();
    doLoad(4'b0101);
    sendCmd(3'd7, 4'b1111, 8'd4);
    nChecks++;
    if ({illegal, done, cmdIf.cmd_ready, j_out, k_out} !== {3'b111, 8'h00})
      $display("FAIL op7_illegal: got ill/done/rdy=%b j=%b k=%b, required 111/0000/0000",
               {illegal, done, cmdIf.cmd_ready}, j_out, k_out);
    else nPass++;
    sendCmd(3'd0, 4'b1111, '0);
    nChecks++;
    if ({illegal, done, busy, j_out} !== {3'b010, 4'b0000})
      $display("FAIL nop_done: got ill/done/busy=%b j=%b, required 010/0000",
               {illegal, done, busy}, j_out);
    else nPass++;
    @(negedge clk);
    nChecks++;
    if ({done, q_in, mismatch} !== {1'b0, 4'b0101, 1'b0})
      $display("FAIL nop_after: got done=%b q=%b mis=%b, required 0/0101/0", done, q_in, mismatch);
    else nPass++;
  endtask

  task automatic test_len0();
    sendCmd(3'd5, '0, 8'd0);
    @(negedge clk);
    nChecks++;
    if ({j_out, done, busy} !== {4'b0000, 2'b01})
      $display("FAIL len0_mid: got j=%b done=%b busy=%b, required 0000/0/1", j_out, done, busy);
    else nPass++;
    @(negedge clk);
    nChecks++;
    if ({done, mismatch, q_in} !== {2'b10, 4'b0101})
      $display("FAIL len0_done: got done/mis=%b q=%b, required 10/0101", {done, mismatch}, q_in);
    else nPass++;
  endtask

  task automatic test_back_to_back();
    sendCmd(3'd1, 4'b0011, '0);
    cmdIf.cmd_valid = 1'b1;
    cmdIf.cmd_op    = 3'd4;
    cmdIf.cmd_data  = 4'b1111;
    @(negedge clk);
    cmdIf.cmd_valid = 1'b0;
    nChecks++;
    if ({j_out, k_out} !== 8'h00)
      $display("FAIL busy_ignore_drive: got j=%b k=%b, required 0000/0000", j_out, k_out);
    else nPass++;
    @(negedge clk);
    nChecks++;
    if ({done, q_in} !== {1'b1, 4'b0011})
      $display("FAIL busy_ignore_done: got done=%b q=%b, required 1/0011", done, q_in);
    else nPass++;
    sendCmd(3'd4, 4'b0011, '0);
    nChecks++;
    if ({j_out, k_out} !== {4'b0011, 4'b0011})
      $display("FAIL b2b_drive: got j=%b k=%b, required 0011/0011", j_out, k_out);
    else nPass++;
    repeat (2) @(negedge clk);
    nChecks++;
    if ({done, mismatch, q_in} !== {2'b10, 4'b0000})
      $display("FAIL b2b_done: got done/mis=%b q=%b, required 10/0000", {done, mismatch}, q_in);
    else nPass++;
  endtask

  task automatic test_mismatch();
    bankStuck = 1'b1;
    sendCmd(3'd3, '0, '0);
    nChecks++;
    if ({j_out, k_out} !== {4'b1111, 4'b0000})
      $display("FAIL set_drive: got j=%b k=%b, required 1111/0000", j_out, k_out);
    else nPass++;
    repeat (2) @(negedge clk);
    nChecks++;
    if ({done, mismatch} !== 2'b11)
      $display("FAIL mismatch_set: got done/mis=%b, required 11", {done, mismatch});
    else nPass++;
    bankStuck = 1'b0;
    sendCmd(3'd0, '0, '0);
    @(negedge clk);
    nChecks++;
    if (mismatch !== 1'b1) $display("FAIL mismatch_sticky: got %b, required 1", mismatch);
    else nPass++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    nChecks++;
    if ({mismatch, q_in} !== {1'b0, 4'b0000})
      $display("FAIL mismatch_reset: got mis=%b q=%b, required 0/0000", mismatch, q_in);
    else nPass++;
  endtask

  task automatic test_reset_mid();
    logic sawDone;
    sendCmd(3'd5, '0, 8'd8);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    nChecks++;
    if ({j_out, k_out, cmdIf.cmd_ready, done, wrap, q_in} !== {8'h00, 3'b100, 4'b0000})
      $display("FAIL reset_mid: got j=%b k=%b rdy/done/wrap=%b q=%b, required 0000/0000/100/0000",
               j_out, k_out, {cmdIf.cmd_ready, done, wrap}, q_in);
    else nPass++;
    reset = 1'b0;
    sawDone = 1'b0;
    repeat (4) begin
      @(negedge clk);
      sawDone = sawDone | done | busy;
    end
    nChecks++;
    if (sawDone !== 1'b0)
      $display("FAIL reset_mid_quiet: got done/busy activity=%b, required 0", sawDone);
    else nPass++;
    sendCmd(3'd5, '0, 8'd1);
    @(negedge clk);
    nChecks++;
    if ({j_out, k_out} !== {4'b0001, 4'b0001})
      $display("FAIL reset_mid_exp: got j=%b k=%b, required 0001/0001", j_out, k_out);
    else nPass++;
    repeat (2) @(negedge clk);
    nChecks++;
    if ({done, mismatch, q_in} !== {2'b10, 4'b0001})
      $display("FAIL reset_mid_done: got done/mis=%b q=%b, required 10/0001", {done, mismatch}, q_in);
    else nPass++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_toggle();
    test_cnt_up();
    test_cnt_dn();
    test_illegal_nop();
    test_len0();
    test_back_to_back();
    test_mismatch();
    test_reset_mid();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
